// File: rtl/ult_ranger_pkg.sv
// ---------------------------------------------------------------------------
// ult_pkg : shared types and default timing for the ultrasonic ranger.
//   - ult_state_t : controller state encoding
//   - ULT_*_CYCLES: default timing constants for a 25 MHz clk_in
//   - ULT_MAX_CM  : distance saturation value (HC-SR04 rated range)
// ---------------------------------------------------------------------------
package ult_pkg;

  typedef enum logic [2:0] {
    ULT_IDLE,
    ULT_TRIG,
    ULT_WAIT,
    ULT_MEAS,
    ULT_DONE,
    ULT_HOLD
  } ult_state_t;

  localparam int ULT_TRIG_CYCLES    = 250;      // 10 us
  localparam int ULT_CM_CYCLES      = 1450;     // 58 us per cm
  localparam int ULT_TIMEOUT_CYCLES = 950000;   // 38 ms
  localparam int ULT_HOLDOFF_CYCLES = 1500000;  // 60 ms
  localparam int ULT_MAX_CM         = 400;

endpackage

// File: rtl/ult_ranger_sync_edge.sv
// ---------------------------------------------------------------------------
// ult_sync_edge : two-flop synchroniser for an asynchronous input followed by
// a rise/fall pulse detector on the synchronised level. Edge pulses appear
// two clk_in cycles after the input changes.
// Ports:
//   clk_in  - clock
//   rst     - synchronous active-high reset, clears all flops
//   i_async - asynchronous input pin
//   o_rise  - one-cycle pulse on a synchronised 0->1 transition
//   o_fall  - one-cycle pulse on a synchronised 1->0 transition
// ---------------------------------------------------------------------------
module ult_sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ult_ranger.sv
// ---------------------------------------------------------------------------
// ult_ranger : HC-SR04-class ultrasonic ranging controller.
// Issues a TRIG_CYCLES trigger pulse, times the echo pulse, converts its width
// to centimetres (floor(width / CM_CYCLES), saturating at MAX_CM) and then
// enforces a HOLDOFF_CYCLES quiet period before the next ping.
// Ports:
//   clk_in      - clock
//   rst         - synchronous active-high reset (aborts any measurement)
//   start       - measurement request, level-sampled in IDLE only
//   auto_mode   - (ULT_RANGER_AUTO_EN only) re-trigger straight from HOLDOFF
//   echo        - asynchronous sensor echo pin
//   trig        - sensor trigger pin
//   busy        - high in every state except IDLE
//   done        - one-cycle strobe, result outputs updated this cycle
//   distance_cm - last range in cm (MAX_CM on timeout), held
//   timeout     - last measurement had no echo or an over-long echo, held
// Optional feature macro: ULT_RANGER_AUTO_EN (adds auto_mode).
// ---------------------------------------------------------------------------
module ult_ranger
  import ult_pkg::*;
#(
  parameter int TRIG_CYCLES    = ULT_TRIG_CYCLES,
  parameter int CM_CYCLES      = ULT_CM_CYCLES,
  parameter int TIMEOUT_CYCLES = ULT_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = ULT_HOLDOFF_CYCLES,
  parameter int MAX_CM         = ULT_MAX_CM,
  parameter int DIST_W         = 9,
  parameter int CNT_W          = 21
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
`ifdef ULT_RANGER_AUTO_EN
  input  logic              auto_mode,
`endif
  input  logic              echo,
  output logic              trig,
  output logic              busy,
  output logic              done,
  output logic [DIST_W-1:0] distance_cm,
  output logic              timeout
);

  localparam logic [CNT_W-1:0]  LP_TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LP_CM_LAST   = CNT_W'(CM_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LP_TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LP_TO        = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  LP_HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [DIST_W-1:0] LP_MAX_CM    = DIST_W'(MAX_CM);

  // Prescaler wraps after CM_CYCLES counted echo cycles.
  function automatic logic pre_wrap(input logic [CNT_W-1:0] pre);
    return pre == LP_CM_LAST;
  endfunction

  function automatic logic [CNT_W-1:0] pre_step(input logic [CNT_W-1:0] pre);
    return pre_wrap(pre) ? '0 : pre + 1'b1;
  endfunction

  function automatic logic [DIST_W-1:0] cm_sat_inc(input logic [DIST_W-1:0] cm);
    return (cm >= LP_MAX_CM) ? LP_MAX_CM : cm + 1'b1;
  endfunction

  ult_state_t        r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  r_pre, w_pre_nxt;
  logic [DIST_W-1:0] r_cm, w_cm_nxt;
  logic              w_fin_to;
  logic              w_rise, w_fall;
  logic              r_trig, r_busy, r_done, r_timeout;
  logic [DIST_W-1:0] r_dist;

  ult_sync_edge u_echo_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .i_async(echo),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // In MEAS r_cnt holds the number of synchronised echo-high cycles seen so
  // far. The rise cycle itself is counted on entry so a pulse of N input
  // cycles yields exactly N counts by the time the fall pulse arrives.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_pre_nxt = r_pre;
    w_cm_nxt  = r_cm;
    w_fin_to  = 1'b0;
    case (r_state)
      ULT_IDLE: begin
        if (start) begin
          w_next    = ULT_TRIG;
          w_cnt_nxt = '0;
        end
      end
      ULT_TRIG: begin
        if (r_cnt == LP_TRIG_LAST) begin
          w_next    = ULT_WAIT;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ULT_WAIT: begin
        // Only an edge starts a measurement, so a stale high level is ignored.
        if (w_rise) begin
          w_next    = ULT_MEAS;
          w_cnt_nxt = CNT_W'(1);
          w_pre_nxt = pre_step('0);
          w_cm_nxt  = pre_wrap('0) ? cm_sat_inc('0) : '0;
        end else if (r_cnt == LP_TO_LAST) begin
          w_next   = ULT_DONE;
          w_fin_to = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ULT_MEAS: begin
        // Fall is checked first: a pulse of exactly TIMEOUT_CYCLES is valid.
        if (w_fall) begin
          w_next = ULT_DONE;
        end else if (r_cnt >= LP_TO) begin
          w_next   = ULT_DONE;
          w_fin_to = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          w_pre_nxt = pre_step(r_pre);
          if (pre_wrap(r_pre)) w_cm_nxt = cm_sat_inc(r_cm);
        end
      end
      ULT_DONE: begin
        w_next    = ULT_HOLD;
        w_cnt_nxt = '0;
      end
      ULT_HOLD: begin
        // HOLD lasts exactly HOLDOFF_CYCLES cycles after the done strobe.
        if (r_cnt == LP_HOLD_LAST) begin
          w_cnt_nxt = '0;
`ifdef ULT_RANGER_AUTO_EN
          w_next = auto_mode ? ULT_TRIG : ULT_IDLE;
`else
          w_next = ULT_IDLE;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_next = ULT_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the sensor pin never
  // sees decode glitches and all of them react at the same edge as reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= ULT_IDLE;
      r_cnt     <= '0;
      r_pre     <= '0;
      r_cm      <= '0;
      r_trig    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dist    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_pre   <= w_pre_nxt;
      r_cm    <= w_cm_nxt;
      r_trig  <= (w_next == ULT_TRIG);
      r_busy  <= (w_next != ULT_IDLE);
      r_done  <= (w_next == ULT_DONE);
      if (w_next == ULT_DONE) begin
        r_dist    <= w_fin_to ? LP_MAX_CM : r_cm;
        r_timeout <= w_fin_to;
      end
    end
  end

  assign trig        = r_trig;
  assign busy        = r_busy;
  assign done        = r_done;
  assign distance_cm = r_dist;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_ult_ranger.sv
// ---------------------------------------------------------------------------
// tb_ult_ranger : scoreboard bench for ult_ranger with scaled-down timing.
// Expected results are queued when a measurement is issued and checked by an
// independent monitor on every done strobe.
// ---------------------------------------------------------------------------
module tb_ult_ranger;

  localparam int TRIG    = 5;
  localparam int CM      = 10;
  localparam int TO      = 200;
  localparam int HOLD    = 30;
  localparam int MAXCM   = 15;
  localparam int DIST_W  = 9;
  localparam int CNT_W   = 12;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              start;
  logic              echo;
  logic              trig;
  logic              busy;
  logic              done;
  logic [DIST_W-1:0] distance_cm;
  logic              timeout;
`ifdef ULT_RANGER_AUTO_EN
  logic              auto_mode;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_d_q[$];
  bit exp_to_q[$];
  int tlen   = 0;

  ult_ranger #(
    .TRIG_CYCLES   (TRIG),
    .CM_CYCLES     (CM),
    .TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HOLD),
    .MAX_CM        (MAXCM),
    .DIST_W        (DIST_W),
    .CNT_W         (CNT_W)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .start      (start),
`ifdef ULT_RANGER_AUTO_EN
    .auto_mode  (auto_mode),
`endif
    .echo       (echo),
    .trig       (trig),
    .busy       (busy),
    .done       (done),
    .distance_cm(distance_cm),
    .timeout    (timeout)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  // Result monitor: pops the scoreboard on every done strobe.
  always @(negedge clk_in) begin
    if (!rst && done) begin
      checks++;
      if (exp_d_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: distance_cm=%0d timeout=%0d", distance_cm, timeout);
      end else begin
        int  ed;
        bit  et;
        ed = exp_d_q.pop_front();
        et = exp_to_q.pop_front();
        if (distance_cm !== DIST_W'(ed) || timeout !== et) begin
          errors++;
          $display("FAIL result: got dist=%0d to=%0b, expected dist=%0d to=%0b",
                   distance_cm, timeout, ed, et);
        end
      end
    end
  end

  // Trigger monitor: every trig pulse must last exactly TRIG cycles.
  always @(negedge clk_in) begin
    if (rst) tlen = 0;
    else if (trig) tlen++;
    else if (tlen != 0) begin
      checks++;
      if (tlen != TRIG) begin
        errors++;
        $display("FAIL trig_width: got %0d cycles, expected %0d", tlen, TRIG);
      end
      tlen = 0;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input int d, input bit t);
    exp_d_q.push_back(d);
    exp_to_q.push_back(t);
  endtask

  task automatic pulse_start();
    check("idle_before_start", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_response", {busy, trig, done}, 3'b110);
  endtask

  // Waits for the next trig high->low transition; returns the first low cycle.
  task automatic wait_trig_fall(output int fall_cyc);
    bit seen;
    bit bad;
    seen = 0;
    bad  = 0;
    fall_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      if (trig) begin
        seen = 1;
        if (done) bad = 1;
      end else if (seen) begin
        fall_cyc = cyc;
        break;
      end
    end
    check("trig_fall_seen", (fall_cyc >= 0) ? 1 : 0, 1);
    check("no_done_in_trig", bad, 0);
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    check("done_seen", (dcyc >= 0) ? 1 : 0, 1);
  endtask

  // Called at the done negedge; busy must drop HOLD+1 cycles later.
  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk_in);
      k++;
    end while (busy && k < 1000);
    check("busy_fall_delay", k, HOLD + 1);
  endtask

  task automatic measure(input int dly, input int width, input int ed, input bit et);
    int f;
    int d;
    push_exp(ed, et);
    pulse_start();
    wait_trig_fall(f);
    if (width > 0) begin
      repeat (dly) tick();
      echo = 1'b1;
      repeat (width) tick();
      echo = 1'b0;
    end
    wait_done(d);
    if (width == 0) check("no_echo_done_delay", d - f, TO);
    wait_idle();
  endtask

  initial begin
    int f;
    int d;
    rst   = 1'b1;
    start = 1'b0;
    echo  = 1'b0;
`ifdef ULT_RANGER_AUTO_EN
    auto_mode = 1'b0;
`endif
    repeat (3) tick();
    check("reset_outputs", {trig, busy, done, timeout}, 4'b0000);
    check("reset_distance", distance_cm, 0);
    rst = 1'b0;
    repeat (2) tick();

    // 100-cycle echo -> exactly 10 cm
    measure(20, 100, 10, 1'b0);
    // 29 cycles -> 2 cm, partial centimetre truncated
    measure(7, 29, 2, 1'b0);
    // sub-centimetre and exact one-centimetre pulses
    measure(3, 9, 0, 1'b0);
    measure(3, 10, 1, 1'b0);
    // no echo at all
    measure(0, 0, MAXCM, 1'b1);
    // 18 cm worth of echo saturates at MAXCM without timeout
    measure(5, 180, MAXCM, 1'b0);
    // exactly TO cycles: fall wins over timeout
    measure(5, TO, MAXCM, 1'b0);
    // one cycle longer: timeout
    measure(5, TO + 1, MAXCM, 1'b1);

    // normal result first so the reset-to-zero check is meaningful
    measure(4, 60, 6, 1'b0);

    // reset in the middle of MEASURE aborts everything
    pulse_start();
    wait_trig_fall(f);
    repeat (5) tick();
    echo = 1'b1;
    repeat (40) tick();
    rst = 1'b1;
    tick();
    check("abort_ctrl", {trig, busy, done, timeout}, 4'b0000);
    check("abort_distance", distance_cm, 0);
    rst  = 1'b0;
    echo = 1'b0;
    repeat (4) tick();
    measure(6, 50, 5, 1'b0);

    // stale echo level at the end of TRIG is ignored until it re-rises
    push_exp(2, 1'b0);
    pulse_start();
    tick();
    echo = 1'b1;
    wait_trig_fall(f);
    repeat (10) tick();
    echo = 1'b0;
    repeat (5) tick();
    echo = 1'b1;
    repeat (29) tick();
    echo = 1'b0;
    wait_done(d);
    wait_idle();

`ifdef ULT_RANGER_AUTO_EN
    // auto mode: second ping follows HOLDOFF without start
    auto_mode = 1'b1;
    push_exp(MAXCM, 1'b1);
    push_exp(MAXCM, 1'b1);
    pulse_start();
    wait_trig_fall(f);
    wait_done(d);
    wait_trig_fall(f);
    auto_mode = 1'b0;
    wait_done(d);
    wait_idle();
`endif

    repeat (5) tick();
    check("scoreboard_drained", exp_d_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ult_ranger.md
Name: ult_ranger

Overview:
Parametrised ultrasonic ranging controller for HC-SR04-class sensors. It generates the trigger pulse and then times the echo pulse. The echo width is converted to centimetres with a cycle prescaler. Per measurement it reports a distance, a timeout flag, and a one-cycle done strobe. A mandatory hold-off interval separates successive pings. It sits between the system control logic and the sensor pins, and its outputs feed the display/decision logic.

Parameters:
TRIG_CYCLES, 250, trigger high time in clk_in cycles (10 us at 25 MHz)
CM_CYCLES, 1450, clk_in cycles per centimetre of range (58 us at 25 MHz)
TIMEOUT_CYCLES, 950000, max wait for echo rise and max echo width (38 ms)
HOLDOFF_CYCLES, 1500000, quiet time after done before next ping (60 ms)
MAX_CM, 400, saturation value of distance_cm
DIST_W, 9, width of distance_cm
CNT_W, 21, width of internal cycle counter; must hold max(TIMEOUT_CYCLES, HOLDOFF_CYCLES)

Ports:
clk_in  input  1  system clock; the block has one clock
rst  input  1  reset, synchronous, active-high
start  input  1  measurement request, level-sampled in IDLE
echo  input  1  asynchronous sensor echo pin
trig  output  1  sensor trigger pin
busy  output  1  high in every state except IDLE
done  output  1  one-cycle strobe: result registers updated this cycle
distance_cm  output  DIST_W  last measured range in cm; held between measurements
timeout  output  1  high when the last measurement had no echo or an over-long echo; held

Behaviour:
- Reset (rst=1 at a clk_in edge):
  - State becomes IDLE; counters clear.
  - trig=0, busy=0, done=0, distance_cm=0, timeout=0; synchroniser flops clear.
  - Reset wins over every other event and aborts any state mid-operation. trig falls at the same edge.
- Echo is passed through a 2-flop synchroniser. Rise/fall are detected on the synchronised signal, adding 2 cycles of latency.
- States:
  - IDLE:
    - If start=1, go to TRIG and clear the counter. start is ignored in all other states; no queuing.
  - TRIG:
    - trig=1 for exactly TRIG_CYCLES cycles, starting the cycle after start is sampled.
    - Then go to WAIT_ECHO and clear the counter.
  - WAIT_ECHO:
    - Wait for a synchronised echo rising edge. An echo already high on entry is ignored until it falls and rises again.
    - Rise detected: go to MEASURE.
    - Counter reaches TIMEOUT_CYCLES-1 with no rise: finish with timeout.
  - MEASURE:
    - Prescaler counts 0..CM_CYCLES-1. On each wrap, cm_acc increments, saturating at MAX_CM.
    - Echo fall: finish normally.
    - Total echo cycles reach TIMEOUT_CYCLES: finish with timeout.
  - DONE (one cycle):
    - done=1. Normal finish: distance_cm=cm_acc, timeout=0.
    - Timeout finish: distance_cm=MAX_CM, timeout=1.
    - Go to HOLDOFF.
  - HOLDOFF:
    - Count HOLDOFF_CYCLES, then go to IDLE. busy stays high.
- Arithmetic: distance = floor(echo_cycles / CM_CYCLES), capped at MAX_CM. A partial centimetre is truncated.
- Echo fall and timeout in the same cycle: normal finish takes priority.
- start held high continuously: one measurement per full cycle (TRIG + echo + HOLDOFF).

Optional Feature:
- Macro ULT_RANGER_AUTO_EN.
- Defined:
  - Adds input auto_mode (1 bit).
  - While auto_mode=1, HOLDOFF goes directly to TRIG without needing start, giving continuous ranging.
  - auto_mode=0 behaves as the base block. start is still accepted in IDLE.
- Not defined: port absent; a measurement only starts via start.

Decomposition:
- Shared package ult_pkg holds:
  - state enum ULT_IDLE/ULT_TRIG/ULT_WAIT/ULT_MEAS/ULT_DONE/ULT_HOLD;
  - default timing constants for 25 MHz (TRIG, CM, TIMEOUT, HOLDOFF);
  - MAX_CM.
- One natural sub-module: ult_sync_edge, a 2-flop synchroniser plus rise/fall pulse detector. It can be reused for other sensor inputs.

Test Plan:
- Reset then start=1 for one cycle: trig high exactly 250 cycles; busy=1 from the next cycle; done=0 throughout TRIG.
- Echo rises 1000 cycles after trig falls and stays high 14500 cycles: one done pulse; distance_cm=10; timeout=0; busy falls 1500000 cycles after done.
- Echo never rises: done 950000 cycles after trig falls; distance_cm=400; timeout=1.
- Echo high 900000 cycles (>400 cm): distance_cm saturates at 400; timeout=0. Echo high 960000 cycles: timeout=1.
- Assert rst during MEASURE: next cycle trig=0, busy=0, distance_cm=0. The following start performs a full clean measurement.
- Echo already high when TRIG ends, falls, then rises and stays high 2900 cycles: distance_cm=2 (stale level ignored). With ULT_RANGER_AUTO_EN and auto_mode=1, a new trig follows HOLDOFF without start.
